// File: rtl/axis_rr_arbiter_pkg.sv
// Shared definitions for the AXI-stream arbiter tree: FSM state encodings
// and the index-width helper used to size source IDs.
package axis_arb_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Width needed to index n items; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N (N need not be a power of two).
module rr_priority_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] sel,
    output logic            any
);

    logic [ID_W:0] scan_idx;

    always_comb begin
        sel      = '0;
        any      = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N)) begin
                scan_idx = scan_idx - (ID_W+1)'(N);
            end
            if (!any && req[scan_idx[ID_W-1:0]]) begin
                any = 1'b1;
                sel = scan_idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter sharing one AXI-stream output between N
// requesters, with a registered output stage that tags each beat with its source.
module axis_rr_arbiter
    import axis_arb_defs::*;
#(
    parameter int N           = 4,
    parameter int WIDTH       = 32,
    parameter bit PACKET_MODE = 1'b1,
    parameter int BURST_MAX   = 16,
    localparam int ID_W       = id_width(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   s_rx_tdata,
    input  logic [N-1:0]         s_rx_tvalid,
    input  logic [N-1:0]         s_rx_tlast,
    output logic [N-1:0]         s_rx_tready,
    output logic [WIDTH-1:0]     m_tx_tdata,
    output logic                 m_tx_tlast,
    output logic [ID_W-1:0]      m_tx_tid,
    output logic                 m_tx_tvalid,
    input  logic                 m_tx_tready,
    output logic                 grant_active,
    output logic [ID_W-1:0]      grant_id
);

    localparam int              CNT_W       = id_width(BURST_MAX + 1);
    localparam bit              HAS_CAP     = (BURST_MAX > 0);
    localparam bit              SINGLE_BEAT = !PACKET_MODE && (BURST_MAX == 0);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'((BURST_MAX > 0) ? BURST_MAX - 1 : 0);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0]   m_tx_tdata_q, m_tx_tdata_d;
    logic               m_tx_tlast_q, m_tx_tlast_d;
    logic [ID_W-1:0]    m_tx_tid_q, m_tx_tid_d;
    logic               m_tx_tvalid_q, m_tx_tvalid_d;

    logic [ID_W-1:0]    pick_sel;
    logic               pick_any;
    logic               out_ready;
    logic               g_valid;
    logic               g_last;
    logic [WIDTH-1:0]   g_data;
    logic               accept;
    logic               cap_hit;
    logic               release_grant;

    rr_priority_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req  (s_rx_tvalid),
        .ptr  (rr_ptr_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    assign out_ready = !m_tx_tvalid_q || m_tx_tready;

    // Mux the granted source onto a single lane; only that source sees ready.
    always_comb begin
        g_valid     = 1'b0;
        g_last      = 1'b0;
        g_data      = '0;
        s_rx_tready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                g_valid = s_rx_tvalid[i];
                g_last  = s_rx_tlast[i];
                g_data  = s_rx_tdata[i*WIDTH +: WIDTH];
                if (state_q == ST_GRANT) begin
                    s_rx_tready[i] = out_ready;
                end
            end
        end
    end

    always_comb begin
        accept        = (state_q == ST_GRANT) && g_valid && out_ready;
        cap_hit       = HAS_CAP && (beat_cnt_q == CAP_LAST);
        release_grant = 1'b0;
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        beat_cnt_d    = beat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_sel;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if ((PACKET_MODE && g_last) || cap_hit || SINGLE_BEAT) begin
                        release_grant = 1'b1;
                    end
                end
                // Without packet framing a stalled source gives up its slot.
                if (!PACKET_MODE && !g_valid) begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    rr_ptr_d = (grant_id_q == ID_W'(N - 1)) ? '0 : grant_id_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        m_tx_tdata_d  = m_tx_tdata_q;
        m_tx_tlast_d  = m_tx_tlast_q;
        m_tx_tid_d    = m_tx_tid_q;
        m_tx_tvalid_d = m_tx_tvalid_q;
        if (accept) begin
            m_tx_tdata_d  = g_data;
            m_tx_tlast_d  = g_last || cap_hit;
            m_tx_tid_d    = grant_id_q;
            m_tx_tvalid_d = 1'b1;
        end else if (m_tx_tready) begin
            m_tx_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            beat_cnt_q    <= '0;
            m_tx_tdata_q  <= '0;
            m_tx_tlast_q  <= 1'b0;
            m_tx_tid_q    <= '0;
            m_tx_tvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            beat_cnt_q    <= beat_cnt_d;
            m_tx_tdata_q  <= m_tx_tdata_d;
            m_tx_tlast_q  <= m_tx_tlast_d;
            m_tx_tid_q    <= m_tx_tid_d;
            m_tx_tvalid_q <= m_tx_tvalid_d;
        end
    end

    assign m_tx_tdata   = m_tx_tdata_q;
    assign m_tx_tlast   = m_tx_tlast_q;
    assign m_tx_tid     = m_tx_tid_q;
    assign m_tx_tvalid  = m_tx_tvalid_q;
    assign grant_active = (state_q == ST_GRANT);
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: a 4-source packet-mode instance with a
// 4-beat cap, plus a 3-source non-packet single-beat instance.
module tb_axis_rr_arbiter;

    localparam int W = 32;

    typedef struct {
        int         tid;
        logic [W-1:0] data;
        logic       last;
        int         cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    logic [4*W-1:0] sTdata;
    logic [3:0]     sTvalid, sTlast, sTready;
    logic [W-1:0]   mTdata;
    logic           mTlast, mTvalid, mTready, grantActive;
    logic [1:0]     mTid, grantId;

    logic [3*W-1:0] uTdata;
    logic [2:0]     uTvalid, uTlast, uTready;
    logic [W-1:0]   uMdata;
    logic           uMlast, uMvalid, uMready, uGrantActive;
    logic [1:0]     uMtid, uGrantId;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [W:0] srcQ [4][$];
    beat_t outLog[$];

    axis_rr_arbiter #(.N(4), .WIDTH(W), .PACKET_MODE(1), .BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rstN),
        .s_rx_tdata(sTdata), .s_rx_tvalid(sTvalid), .s_rx_tlast(sTlast), .s_rx_tready(sTready),
        .m_tx_tdata(mTdata), .m_tx_tlast(mTlast), .m_tx_tid(mTid), .m_tx_tvalid(mTvalid),
        .m_tx_tready(mTready), .grant_active(grantActive), .grant_id(grantId)
    );

    axis_rr_arbiter #(.N(3), .WIDTH(W), .PACKET_MODE(0), .BURST_MAX(0)) dutSingle (
        .clk(clk), .rst_n(rstN),
        .s_rx_tdata(uTdata), .s_rx_tvalid(uTvalid), .s_rx_tlast(uTlast), .s_rx_tready(uTready),
        .m_tx_tdata(uMdata), .m_tx_tlast(uMlast), .m_tx_tid(uMtid), .m_tx_tvalid(uMvalid),
        .m_tx_tready(uMready), .grant_active(uGrantActive), .grant_id(uGrantId)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < 4; i++) begin
            if (srcQ[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic sendPacket(input int src, input int len, input logic [W-1:0] base);
        for (int b = 0; b < len; b++) begin
            srcQ[src].push_back({(b == len - 1), base + W'(b)});
        end
    endtask

    // One clock of the main instance: drive queue heads, log output handshakes, pop accepted beats.
    task automatic applyStimulus(input logic rdy);
        @(negedge clk);
        cyc++;
        mTready = rdy;
        for (int i = 0; i < 4; i++) begin
            if (srcQ[i].size() != 0) begin
                sTvalid[i]         = 1'b1;
                sTlast[i]          = srcQ[i][0][W];
                sTdata[i*W +: W]   = srcQ[i][0][W-1:0];
            end else begin
                sTvalid[i]         = 1'b0;
                sTlast[i]          = 1'b0;
                sTdata[i*W +: W]   = '0;
            end
        end
        #1;
        if (mTvalid && mTready) outLog.push_back('{int'(mTid), mTdata, mTlast, cyc});
        for (int i = 0; i < 4; i++) begin
            if (sTvalid[i] && sTready[i]) void'(srcQ[i].pop_front());
        end
    endtask

    task automatic runUntilIdle(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b1);
            n++;
        end while ((pending() || mTvalid || grantActive) && n < budget);
        checkOutput({tag, "_drained"}, 64'(!(pending() || mTvalid || grantActive)), 64'd1);
    endtask

    task automatic uStep(input logic [2:0] mask);
        @(negedge clk);
        cyc++;
        uTvalid = mask;
        #1;
    endtask

    initial begin
        int startCyc;
        int order[8];
        logic [W-1:0] expData;

        rstN = 1'b0;
        sTdata = '0; sTvalid = '0; sTlast = '0; mTready = 1'b1;
        uTdata = {32'h2222_0002, 32'h1111_0001, 32'h5A5A_0000};
        uTvalid = '0; uTlast = '0; uMready = 1'b1;

        #3;
        checkOutput("rst_tvalid", 64'(mTvalid), 64'd0);
        checkOutput("rst_tdata", 64'(mTdata), 64'd0);
        checkOutput("rst_tlast", 64'(mTlast), 64'd0);
        checkOutput("rst_tid", 64'(mTid), 64'd0);
        checkOutput("rst_tready", 64'(sTready), 64'd0);
        checkOutput("rst_gactive", 64'(grantActive), 64'd0);
        checkOutput("rst_gid", 64'(grantId), 64'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Single source: src2 sends A,B,C.
        $display("[TB] single source packet");
        sendPacket(2, 3, 32'hA000_0200);
        startCyc = cyc + 1;
        runUntilIdle(30, "t1");
        checkOutput("t1_count", 64'(outLog.size()), 64'd3);
        if (outLog.size() == 3) begin
            checkOutput("t1_latency", 64'(outLog[0].cyc), 64'(startCyc + 2));
            for (int k = 0; k < 3; k++) begin
                checkOutput("t1_tid", 64'(outLog[k].tid), 64'd2);
                checkOutput("t1_data", 64'(outLog[k].data), 64'(32'hA000_0200 + k));
                checkOutput("t1_last", 64'(outLog[k].last), 64'(k == 2));
                if (k > 0) checkOutput("t1_gap", 64'(outLog[k].cyc - outLog[k-1].cyc), 64'd1);
            end
        end
        outLog.delete();

        // All four request two 2-beat packets; pointer sits at 3 after src2 released.
        $display("[TB] all sources round robin");
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 4; s++) sendPacket(s, 2, 32'hB000_0000 + 32'(s << 8) + 32'(p << 4));
        end
        order = '{3, 0, 1, 2, 3, 0, 1, 2};
        runUntilIdle(80, "t2");
        checkOutput("t2_count", 64'(outLog.size()), 64'd16);
        if (outLog.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
                expData = 32'hB000_0000 + 32'(order[k/2] << 8) + 32'((k / 8) << 4) + 32'(k % 2);
                checkOutput("t2_tid", 64'(outLog[k].tid), 64'(order[k/2]));
                checkOutput("t2_data", 64'(outLog[k].data), 64'(expData));
                checkOutput("t2_last", 64'(outLog[k].last), 64'(k % 2 == 1));
                if (k > 0) checkOutput("t2_gap", 64'(outLog[k].cyc - outLog[k-1].cyc), (k % 2 == 0) ? 64'd2 : 64'd1);
            end
        end
        outLog.delete();

        // Burst cap: 10-beat packet from src1 splits into 4,4,2.
        $display("[TB] burst cap split");
        sendPacket(1, 10, 32'hC100_0000);
        runUntilIdle(60, "t3");
        checkOutput("t3_count", 64'(outLog.size()), 64'd10);
        if (outLog.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                checkOutput("t3_tid", 64'(outLog[k].tid), 64'd1);
                checkOutput("t3_data", 64'(outLog[k].data), 64'(32'hC100_0000 + k));
                checkOutput("t3_last", 64'(outLog[k].last), 64'(k == 3 || k == 7 || k == 9));
                if (k > 0) checkOutput("t3_gap", 64'(outLog[k].cyc - outLog[k-1].cyc), (k == 4 || k == 8) ? 64'd2 : 64'd1);
            end
        end
        outLog.delete();

        // Back-pressure: output stalls for 5 cycles with the first beat held.
        $display("[TB] back-pressure");
        sendPacket(0, 3, 32'hD000_0000);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0);
        checkOutput("t4_hold_valid", 64'(mTvalid), 64'd1);
        checkOutput("t4_hold_data", 64'(mTdata), 64'h0000_0000_D000_0000);
        checkOutput("t4_hold_tid", 64'(mTid), 64'd0);
        checkOutput("t4_hold_ready", 64'(sTready), 64'd0);
        runUntilIdle(30, "t4");
        checkOutput("t4_count", 64'(outLog.size()), 64'd3);
        if (outLog.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput("t4_tid", 64'(outLog[k].tid), 64'd0);
                checkOutput("t4_data", 64'(outLog[k].data), 64'(32'hD000_0000 + k));
                checkOutput("t4_last", 64'(outLog[k].last), 64'(k == 2));
            end
        end
        outLog.delete();

        // Non-packet instance: src0 drops valid while granted, src1 pending.
        $display("[TB] non-packet gap release");
        uStep(3'b011);
        checkOutput("t5_c0_gactive", 64'(uGrantActive), 64'd0);
        uStep(3'b010);
        checkOutput("t5_c1_gactive", 64'(uGrantActive), 64'd1);
        checkOutput("t5_c1_gid", 64'(uGrantId), 64'd0);
        uStep(3'b011);
        checkOutput("t5_c2_gactive", 64'(uGrantActive), 64'd0);
        checkOutput("t5_c2_tvalid", 64'(uMvalid), 64'd0);
        uStep(3'b011);
        checkOutput("t5_c3_gid", 64'(uGrantId), 64'd1);
        checkOutput("t5_c3_tready", 64'(uTready), 64'b010);
        uStep(3'b001);
        checkOutput("t5_c4_tvalid", 64'(uMvalid), 64'd1);
        checkOutput("t5_c4_data", 64'(uMdata), 64'h0000_0000_1111_0001);
        checkOutput("t5_c4_tid", 64'(uMtid), 64'd1);
        uStep(3'b001);
        checkOutput("t5_c5_bubble", 64'(uMvalid), 64'd0);
        checkOutput("t5_c5_gid", 64'(uGrantId), 64'd0);
        checkOutput("t5_c5_gactive", 64'(uGrantActive), 64'd1);
        uStep(3'b000);
        checkOutput("t5_c6_tvalid", 64'(uMvalid), 64'd1);
        checkOutput("t5_c6_data", 64'(uMdata), 64'h0000_0000_5A5A_0000);
        checkOutput("t5_c6_tid", 64'(uMtid), 64'd0);

        // Asynchronous reset mid-packet, then fresh arbitration from index 0.
        $display("[TB] async reset mid-packet");
        sendPacket(1, 6, 32'hE100_0000);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("t6_pre_tvalid", 64'(mTvalid), 64'd1);
        checkOutput("t6_pre_tready", 64'(sTready), 64'b0010);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t6_rst_tvalid", 64'(mTvalid), 64'd0);
        checkOutput("t6_rst_tready", 64'(sTready), 64'd0);
        checkOutput("t6_rst_gactive", 64'(grantActive), 64'd0);
        for (int i = 0; i < 4; i++) srcQ[i].delete();
        outLog.delete();
        @(negedge clk);
        sTvalid = '0;
        sTlast = '0;
        rstN = 1'b1;
        for (int s = 0; s < 4; s++) sendPacket(s, 1, 32'hF000_0000 + 32'(s));
        runUntilIdle(40, "t6");
        checkOutput("t6_count", 64'(outLog.size()), 64'd4);
        if (outLog.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("t6_tid", 64'(outLog[k].tid), 64'(k));
                checkOutput("t6_data", 64'(outLog[k].data), 64'(32'hF000_0000 + k));
                checkOutput("t6_last", 64'(outLog[k].last), 64'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
Round-robin arbiter that shares one AXI-stream channel between N requesters, e.g. several DSP/control sources feeding a single clock-crossing FIFO input. It is packet-aware: once a source is granted, the grant is held until that source's tlast, or until a burst-length cap is reached. The output is a registered stage that carries the source index with every beat.

Parameters:
N, 4, number of requesters (2..16)
WIDTH, 32, tdata width per requester
PACKET_MODE, 1, 1: hold grant until tlast beat; 0: ignore tlast for release
BURST_MAX, 16, max beats per grant (0 = unlimited; only legal with PACKET_MODE=1)
ID_W, clog2(N) (min 1), derived localparam, width of m_tx_tid

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
s_rx_tdata  in  N*WIDTH  requester data, requester i at [i*WIDTH +: WIDTH]
s_rx_tvalid  in  N  per-requester valid
s_rx_tlast  in  N  per-requester end-of-packet
s_rx_tready  out  N  per-requester ready; at most one bit high
m_tx_tdata  out  WIDTH  registered output data
m_tx_tlast  out  1  registered end-of-grant marker (source tlast, or forced at burst cap)
m_tx_tid  out  ID_W  index of the source of the current output beat
m_tx_tvalid  out  1  output valid
m_tx_tready  in  1  output ready
grant_active  out  1  high while in GRANT state
grant_id  out  ID_W  current or last granted index

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - m_tx_tvalid=0, m_tx_tdata=0, m_tx_tlast=0, m_tx_tid=0.
  - s_rx_tready=0, grant_active=0.
- Reset deassertion mid-packet: the arbiter restarts clean in IDLE. Any partial packet is the requester's responsibility.
- Output stage:
  - out_ready = !m_tx_tvalid || m_tx_tready.
  - On an accepted input beat, the output registers load data, tlast and tid, and m_tx_tvalid is set.
  - Otherwise, when m_tx_tready=1, m_tx_tvalid is cleared.
  - Output values are held stable while m_tx_tvalid && !m_tx_tready.
- IDLE:
  - s_rx_tready=0.
  - If any s_rx_tvalid is set, select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo N.
  - Register grant_id=sel, beat_cnt=0, go to GRANT.
  - No data moves in the IDLE cycle.
- GRANT:
  - s_rx_tready[grant_id] = out_ready; all other ready bits are 0.
  - Accepted beat (valid && ready of grant_id): beat_cnt increments.
  - Release happens on the accepted beat when any of these holds:
    - PACKET_MODE=1 and s_rx_tlast[grant_id]=1;
    - BURST_MAX>0 and beat_cnt==BURST_MAX-1;
    - PACKET_MODE=0 and BURST_MAX==0 (single beat per grant).
  - PACKET_MODE=0 only: if the granted source has tvalid=0 for a cycle, release without a transfer.
  - PACKET_MODE=1: a tvalid gap holds the grant indefinitely.
  - On release: rr_ptr = (grant_id+1) mod N, state=IDLE.
- Burst-cap release forces m_tx_tlast=1 on that beat, even if the source tlast=0. The source continues its packet on its next grant.
- Latency and throughput:
  - First output beat is valid 2 cycles after tvalid rises in IDLE (1 arbitration cycle + 1 output register).
  - 1 beat/cycle within a grant.
  - Exactly 1 bubble cycle between grants.
- Fairness:
  - A source that just released has lowest priority next round.
  - With all N requesting, grants cycle 0,1,...,N-1,0.
- Simultaneous events:
  - Release and a new request from another source in the same cycle: the new source is evaluated in the following IDLE cycle.
  - A tvalid change on a non-granted source has no effect during GRANT.
- Wrap-around: rr_ptr and the scan index are computed modulo N; N need not be a power of 2.
- BURST_MAX=0 with PACKET_MODE=0 is single-beat arbitration, not unlimited.

Decomposition:
- Shared package/include axis_arb_defs:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1;
  - clog2-based ID width function.
- One sub-module, rr_priority_pick:
  - purely combinational; inputs req[N] and ptr[ID_W], outputs sel[ID_W] and any;
  - reused by other arbiters in the tree.

Test Plan:
- Single source: N=4, src2 sends 3 beats A,B,C with tlast on C, m_tx_tready=1 → outputs A,B,C with tid=2 starting 2 cycles after tvalid, tlast only on C, rr_ptr=3 after release.
- All four sources continuously send 2-beat packets → grant order 0,1,2,3,0, with one bubble between packets and tids on output in that order.
- BURST_MAX=4, src1 sends a 10-beat packet while src3 is idle → output in groups of 4,4,2 with forced m_tx_tlast on beats 4 and 8, and an IDLE bubble between groups.
- Back-pressure: m_tx_tready=0 for 5 cycles mid-packet → s_rx_tready[grant_id]=0 after the output register fills, output data held stable, no beat lost or duplicated (scoreboard by tid).
- PACKET_MODE=0, src0 drops tvalid mid-stream while src1 is pending → src0 released, src1 granted next, src0 resumes on a later grant.
- Assert rst_n=0 asynchronously mid-packet → m_tx_tvalid and all s_rx_tready go 0 immediately; after release, src0 gets the first grant.
